result_drain_m_axis: RTL and testbench

Transmit-side counterpart of the fetch unit. On a start pulse from the processing array it reads a result matrix out of the result BRAM and sends it over an AXI4-Stream master to the DMA. The BRAM holds rows padded to a multiple of 4 words; pad words are dropped, so only `row_width` words per row go on the stream. TLAST marks the end of the matrix.

---
 rtl/result_drain_m_axis.sv | 231 +++++++++++++++++++++++
 tb/tb_result_drain_m_axis.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_drain_m_axis.sv
// -----------------------------------------------------------------------------
// result_drain_m_axis
//
// Reads a result matrix out of the result BRAM and sends it on an AXI4-Stream
// master. Rows are stored padded to a multiple of 4 words. Only the first
// row_width words of each row go on the stream. TLAST marks the end of the
// matrix.
//
// Optional build macro: ROW_TLAST_EN
//   When it is defined, TLAST is asserted on the last word of every row, so
//   each row is its own packet. done still pulses once per matrix.
//
// Parameters
//   BRAM_DEPTH            address width of the result BRAM (bits)
//   C_M_AXIS_TDATA_WIDTH  stream data width (only 32 is supported)
//
// Ports
//   M_AXIS_ACLK      clock
//   M_AXIS_ARESETN   asynchronous active-low reset
//   VALID_PE2DU      start pulse, sampled only in IDLE
//   row_width        valid words per row (held stable while busy)
//   num_rows         number of rows (held stable while busy)
//   res_addr/res_en  BRAM read port; res_dout is valid one cycle after res_en
//   busy             transfer in progress (RUN, FLUSH, DONE)
//   done             one-cycle pulse when the matrix has been sent
//   M_AXIS_*         AXI4-Stream master (TSTRB is constant 4'hF)
// -----------------------------------------------------------------------------
module result_drain_m_axis #(
    parameter int BRAM_DEPTH           = 10,
    parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
    input  logic                            M_AXIS_ACLK,
    input  logic                            M_AXIS_ARESETN,
    input  logic                            VALID_PE2DU,
    input  logic [31:0]                     row_width,
    input  logic [31:0]                     num_rows,
    output logic [BRAM_DEPTH-1:0]           res_addr,
    output logic                            res_en,
    input  logic [31:0]                     res_dout,
    output logic                            busy,
    output logic                            done,
    output logic                            M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [3:0]                      M_AXIS_TSTRB,
    output logic                            M_AXIS_TLAST,
    input  logic                            M_AXIS_TREADY
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [31:0]             col_cnt_reg;
    logic [31:0]             row_cnt_reg;
    logic [BRAM_DEPTH-1:0]   base_reg;
    logic [BRAM_DEPTH-1:0]   addr_reg;
    logic                    busy_reg;
    logic                    done_reg;

    // Read that was issued last cycle; its data is on res_dout now.
    logic                    pend_reg;
    logic                    pend_last_reg;

    // Two-entry output FIFO.
    logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_data_reg [2];
    logic                            fifo_last_reg [2];
    logic                            fifo_wr_ptr_reg;
    logic                            fifo_rd_ptr_reg;
    logic [1:0]                      fifo_cnt_reg;

    logic [BRAM_DEPTH-1:0]   stride_addr;
    logic [BRAM_DEPTH-1:0]   next_base;
    logic                    last_col;
    logic                    last_row;
    logic                    beat_last;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic [2:0]              commit_cnt;
    logic                    issue;
    logic                    final_beat;

    // The row stride only matters modulo 2^BRAM_DEPTH because the address
    // wraps, so round up in address width rather than 32 bits.
    assign stride_addr = (row_width[BRAM_DEPTH-1:0] + BRAM_DEPTH'(3)) & ~BRAM_DEPTH'(3);
    assign next_base   = base_reg + stride_addr;

    assign last_col = (col_cnt_reg == row_width - 32'd1);
    assign last_row = (row_cnt_reg == num_rows - 32'd1);

`ifdef ROW_TLAST_EN
    assign beat_last = last_col;
`else
    assign beat_last = last_col & last_row;
`endif

    assign fifo_push = pend_reg;
    assign fifo_pop  = (fifo_cnt_reg != 2'd0) & M_AXIS_TREADY;

    // Words already committed to the FIFO once this cycle's pop and the
    // in-flight read settle. A new read is allowed only while that stays
    // below the FIFO depth. Counting the pop lets a 2-entry FIFO sustain one
    // beat per cycle despite the one-cycle BRAM latency.
    assign commit_cnt = {1'b0, fifo_cnt_reg} - {2'b00, fifo_pop} + {2'b00, pend_reg};
    assign issue      = (state_reg == ST_RUN) && (commit_cnt < 3'd2);

    // In FLUSH every read has been issued. A pop that leaves the FIFO empty
    // with nothing in flight is therefore the last beat of the matrix.
    assign final_beat = fifo_pop && (fifo_cnt_reg == 2'd1) && !pend_reg;

    assign res_en        = issue;
    assign res_addr      = addr_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;
    assign M_AXIS_TVALID = (fifo_cnt_reg != 2'd0);
    assign M_AXIS_TDATA  = fifo_data_reg[fifo_rd_ptr_reg];
    assign M_AXIS_TLAST  = fifo_last_reg[fifo_rd_ptr_reg];
    assign M_AXIS_TSTRB  = 4'hF;

    // Control FSM and address generation.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state_reg   <= ST_IDLE;
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            base_reg    <= '0;
            addr_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (VALID_PE2DU) begin
                        col_cnt_reg <= '0;
                        row_cnt_reg <= '0;
                        base_reg    <= '0;
                        addr_reg    <= '0;
                        busy_reg    <= 1'b1;
                        if ((row_width == 32'd0) || (num_rows == 32'd0)) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (last_col) begin
                            col_cnt_reg <= '0;
                            row_cnt_reg <= row_cnt_reg + 32'd1;
                            base_reg    <= next_base;
                            addr_reg    <= next_base;
                            if (last_row) begin
                                state_reg <= ST_FLUSH;
                            end
                        end else begin
                            col_cnt_reg <= col_cnt_reg + 32'd1;
                            addr_reg    <= addr_reg + BRAM_DEPTH'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (final_beat) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Read pipeline: remember which issued word carries TLAST.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            pend_reg      <= 1'b0;
            pend_last_reg <= 1'b0;
        end else begin
            pend_reg <= issue;
            if (issue) begin
                pend_last_reg <= beat_last;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            fifo_wr_ptr_reg <= 1'b0;
            fifo_rd_ptr_reg <= 1'b0;
            fifo_cnt_reg    <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr_reg <= ~fifo_wr_ptr_reg;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_reg <= ~fifo_rd_ptr_reg;
            end
            fifo_cnt_reg <= fifo_cnt_reg + {1'b0, fifo_push} - {1'b0, fifo_pop};
        end
    end

    // FIFO storage. An entry is written only when the write pointer selects
    // it, so the head stays stable while the stream is stalled.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo_entry
            always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
                if (!M_AXIS_ARESETN) begin
                    fifo_data_reg[gi] <= '0;
                    fifo_last_reg[gi] <= 1'b0;
                end else if (fifo_push && (fifo_wr_ptr_reg == 1'(gi))) begin
                    fifo_data_reg[gi] <= C_M_AXIS_TDATA_WIDTH'(res_dout);
                    fifo_last_reg[gi] <= pend_last_reg;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_result_drain_m_axis.sv
module tb_result_drain_m_axis;

    localparam int DEPTH = 4;
    localparam int MEMSZ = 16;
`ifdef ROW_TLAST_EN
    localparam bit ROW_TL = 1'b1;
`else
    localparam bit ROW_TL = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              ARESETN = 1'b1;
    logic              VALID = 1'b0;
    logic [31:0]       row_width = 32'd0;
    logic [31:0]       num_rows = 32'd0;
    logic [DEPTH-1:0]  res_addr;
    logic              res_en;
    logic [31:0]       res_dout = 32'd0;
    logic              busy;
    logic              done;
    logic              TVALID;
    logic [31:0]       TDATA;
    logic [3:0]        TSTRB;
    logic              TLAST;
    logic              TREADY = 1'b0;

    always #5 clk = ~clk;

    result_drain_m_axis #(.BRAM_DEPTH(DEPTH), .C_M_AXIS_TDATA_WIDTH(32)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (ARESETN),
        .VALID_PE2DU    (VALID),
        .row_width      (row_width),
        .num_rows       (num_rows),
        .res_addr       (res_addr),
        .res_en         (res_en),
        .res_dout       (res_dout),
        .busy           (busy),
        .done           (done),
        .M_AXIS_TVALID  (TVALID),
        .M_AXIS_TDATA   (TDATA),
        .M_AXIS_TSTRB   (TSTRB),
        .M_AXIS_TLAST   (TLAST),
        .M_AXIS_TREADY  (TREADY)
    );

    // BRAM model with one cycle of read latency.
    logic [31:0] mem [MEMSZ];
    always @(posedge clk) if (res_en) res_dout <= mem[res_addr];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observation (recorded at the falling edge, compared by the tests)
    logic [31:0] beat_data_q[$];
    bit          beat_last_q[$];
    int          beat_cyc_q[$];
    int          addr_q[$];
    int          done_q[$];
    int          tvalid_cnt, en_cnt, en_first, stall_viol;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (!ARESETN) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (TVALID !== 1'b1 || TDATA !== prev_data || TLAST !== prev_last))
                stall_viol++;
            if (TVALID === 1'b1) tvalid_cnt++;
            if (TVALID === 1'b1 && TREADY) begin
                beat_data_q.push_back(TDATA);
                beat_last_q.push_back(TLAST);
                beat_cyc_q.push_back(cyc);
            end
            if (res_en === 1'b1) begin
                if (en_cnt == 0) en_first = cyc;
                en_cnt++;
                addr_q.push_back(int'(res_addr));
            end
            if (done === 1'b1) done_q.push_back(cyc);
            prev_stall = (TVALID === 1'b1) && !TREADY;
            prev_data  = TDATA;
            prev_last  = TLAST;
        end
    end

    // Reference model: the matrix in row-major order with padded rows.
    logic [31:0] exp_data_q[$];
    bit          exp_last_q[$];
    int          exp_addr_q[$];

    task automatic build_model(input int rw, input int nr);
        int stride;
        int a;
        exp_data_q.delete(); exp_last_q.delete(); exp_addr_q.delete();
        stride = ((rw + 3) / 4) * 4;
        for (int r = 0; r < nr; r++) begin
            for (int c = 0; c < rw; c++) begin
                a = (r * stride + c) % MEMSZ;
                exp_addr_q.push_back(a);
                exp_data_q.push_back(mem[a]);
                exp_last_q.push_back((c == rw - 1) && (ROW_TL || r == nr - 1));
            end
        end
    endtask

    task automatic clear_obs();
        beat_data_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
        addr_q.delete(); done_q.delete();
        tvalid_cnt = 0; en_cnt = 0; en_first = -1; stall_viol = 0;
    endtask

    function automatic logic ready_val(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 2 == 0);
        return 1'($urandom_range(0, 1));
    endfunction

    // Start a transfer and run until the cycle after done (or the budget).
    task automatic run_transfer(input int rw, input int nr, input int mode, output bit timed_out);
        clear_obs();
        row_width = rw; num_rows = nr;
        @(posedge clk); #1;
        VALID = 1'b1; TREADY = ready_val(mode, 0); start_cyc = cyc;
        timed_out = 1'b1;
        for (int k = 1; k < 400; k++) begin
            @(posedge clk); #1;
            VALID = 1'b0;
            TREADY = ready_val(mode, k);
            if (done_q.size() > 0 && cyc > done_q[0]) begin
                timed_out = 1'b0;
                break;
            end
        end
        TREADY = 1'b1;
    endtask

    task automatic test_reset();
        #2 ARESETN = 1'b0;
        #1;
        checks++; if (TVALID !== 1'b0 || TLAST !== 1'b0 || res_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_ctrl: got tvalid=%b tlast=%b res_en=%b busy=%b done=%b, want all 0", TVALID, TLAST, res_en, busy, done);
        end
        checks++; if (res_addr !== '0 || TDATA !== 32'd0) begin
            errors++; $display("FAIL reset_data: got res_addr=%0h tdata=%08h, want 0/0", res_addr, TDATA);
        end
        repeat (3) @(posedge clk);
        #1 ARESETN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (TVALID !== 1'b0 || busy !== 1'b0 || res_en !== 1'b0 || TSTRB !== 4'hF) begin
            errors++; $display("FAIL reset_idle: got tvalid=%b busy=%b res_en=%b tstrb=%h, want 0/0/0/f", TVALID, busy, res_en, TSTRB);
        end
        $display("reset: done");
    endtask

    task automatic test_pad_skip();
        bit to;
        for (int i = 0; i < MEMSZ; i++) mem[i] = i;
        build_model(3, 2);
        run_transfer(3, 2, 0, to);
        checks++; if (to) begin errors++; $display("FAIL pad_timeout: got no done, want done"); end
        checks++; if (beat_data_q.size() != 6) begin
            errors++; $display("FAIL pad_count: got %0d beats, want 6", beat_data_q.size());
        end
        for (int i = 0; i < exp_data_q.size(); i++) begin
            checks++;
            if (i >= beat_data_q.size() || beat_data_q[i] !== exp_data_q[i] || beat_last_q[i] !== exp_last_q[i]) begin
                errors++; $display("FAIL pad_beat[%0d]: got %08h/%b, want %08h/%b", i,
                    (i < beat_data_q.size()) ? beat_data_q[i] : 32'hx, (i < beat_last_q.size()) ? beat_last_q[i] : 1'bx,
                    exp_data_q[i], exp_last_q[i]);
            end
        end
        if (beat_cyc_q.size() == 6) begin
            checks++; if (beat_cyc_q[0] - start_cyc != 3) begin
                errors++; $display("FAIL pad_latency: got first beat in cycle %0d, want 3", beat_cyc_q[0] - start_cyc);
            end
            checks++; if (beat_cyc_q[5] - beat_cyc_q[0] != 5) begin
                errors++; $display("FAIL pad_b2b: got span %0d cycles, want 5", beat_cyc_q[5] - beat_cyc_q[0]);
            end
            checks++; if (done_q.size() != 1 || done_q[0] != beat_cyc_q[5] + 1) begin
                errors++; $display("FAIL pad_done: got %0d pulses first at %0d, want 1 at %0d", done_q.size(),
                    (done_q.size() > 0) ? done_q[0] : -1, beat_cyc_q[5] + 1);
            end
        end
        checks++; if (en_first - start_cyc != 1 || addr_q.size() == 0 || addr_q[0] != 0) begin
            errors++; $display("FAIL pad_first_read: got res_en cycle %0d, want cycle 1 at address 0", en_first - start_cyc);
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pad_busy: got busy=%b after done+1, want 0", busy); end
        $display("pad_skip: %0d beats", beat_data_q.size());
    endtask

    task automatic test_backpressure();
        bit to;
        int nlast;
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
        build_model(8, 1);
        run_transfer(8, 1, 1, to);
        checks++; if (to || beat_data_q.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d beats timeout=%b, want 8", beat_data_q.size(), to);
        end
        for (int i = 0; i < exp_data_q.size(); i++) begin
            checks++;
            if (i >= beat_data_q.size() || beat_data_q[i] !== exp_data_q[i] || beat_last_q[i] !== exp_last_q[i]) begin
                errors++; $display("FAIL bp_beat[%0d]: got %08h, want %08h/%b", i,
                    (i < beat_data_q.size()) ? beat_data_q[i] : 32'hx, exp_data_q[i], exp_last_q[i]);
            end
        end
        nlast = 0;
        foreach (beat_last_q[i]) if (beat_last_q[i]) nlast++;
        checks++; if (nlast != 1 || beat_last_q.size() != 8 || beat_last_q[7] !== 1'b1) begin
            errors++; $display("FAIL bp_tlast: got %0d tlast beats, want exactly beat 7", nlast);
        end
        checks++; if (stall_viol != 0) begin
            errors++; $display("FAIL bp_stable: got %0d unstable stall cycles, want 0", stall_viol);
        end
        $display("backpressure: %0d beats", beat_data_q.size());
    endtask

    task automatic test_zero_size();
        bit to;
        int rws [2] = '{0, 7};
        int nrs [2] = '{5, 0};
        for (int t = 0; t < 2; t++) begin
            run_transfer(rws[t], nrs[t], 0, to);
            checks++; if (to || done_q.size() != 1 || done_q[0] - start_cyc != 1) begin
                errors++; $display("FAIL zero_done[%0d]: got %0d pulses at cycle %0d, want 1 at cycle 1", t,
                    done_q.size(), (done_q.size() > 0) ? done_q[0] - start_cyc : -1);
            end
            checks++; if (tvalid_cnt != 0 || en_cnt != 0) begin
                errors++; $display("FAIL zero_quiet[%0d]: got tvalid cycles=%0d res_en cycles=%0d, want 0/0", t, tvalid_cnt, en_cnt);
            end
            $display("zero_size: rw=%0d nr=%0d", rws[t], nrs[t]);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int k;
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
        clear_obs();
        row_width = 6; num_rows = 3; TREADY = 1'b1;
        @(posedge clk); #1 VALID = 1'b1;
        @(posedge clk); #1 VALID = 1'b0;
        k = 0;
        while (beat_data_q.size() < 2 && k < 50) begin @(negedge clk); k++; end
        checks++; if (beat_data_q.size() < 2) begin
            errors++; $display("FAIL rst_mid_wait: got %0d beats, want 2", beat_data_q.size());
        end
        @(posedge clk); #2;
        checks++; if (TVALID !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got tvalid=%b, want 1", TVALID); end
        ARESETN = 1'b0;
        #1;
        checks++; if (TVALID !== 1'b0 || busy !== 1'b0 || res_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_async: got tvalid=%b busy=%b res_en=%b, want 0/0/0", TVALID, busy, res_en);
        end
        @(posedge clk); #1 ARESETN = 1'b1;
        @(posedge clk);
        build_model(6, 3);
        run_transfer(6, 3, 0, to);
        checks++; if (to || beat_data_q.size() != 18) begin
            errors++; $display("FAIL rst_mid_count: got %0d beats, want 18", beat_data_q.size());
        end
        for (int i = 0; i < exp_data_q.size(); i++) begin
            checks++;
            if (i >= beat_data_q.size() || beat_data_q[i] !== exp_data_q[i] || beat_last_q[i] !== exp_last_q[i]) begin
                errors++; $display("FAIL rst_mid_beat[%0d]: got %08h, want %08h", i,
                    (i < beat_data_q.size()) ? beat_data_q[i] : 32'hx, exp_data_q[i]);
            end
        end
        $display("reset_mid: restart %0d beats", beat_data_q.size());
    endtask

    task automatic test_addr_wrap();
        bit to;
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
        build_model(4, 5);
        run_transfer(4, 5, 0, to);
        checks++; if (to || beat_data_q.size() != 20 || addr_q.size() != 20) begin
            errors++; $display("FAIL wrap_count: got %0d beats %0d reads, want 20/20", beat_data_q.size(), addr_q.size());
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (i >= addr_q.size() || addr_q[i] != exp_addr_q[i] || i >= beat_data_q.size() ||
                beat_data_q[i] !== exp_data_q[i] || beat_last_q[i] !== exp_last_q[i]) begin
                errors++; $display("FAIL wrap[%0d]: got addr %0d data %08h, want addr %0d data %08h last %b", i,
                    (i < addr_q.size()) ? addr_q[i] : -1, (i < beat_data_q.size()) ? beat_data_q[i] : 32'hx,
                    exp_addr_q[i], exp_data_q[i], exp_last_q[i]);
            end
        end
        $display("addr_wrap: %0d reads", addr_q.size());
    endtask

    task automatic test_row_tlast();
        bit to;
        int nlast;
        for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
        build_model(2, 3);
        run_transfer(2, 3, 0, to);
        nlast = 0;
        foreach (beat_last_q[i]) if (beat_last_q[i]) nlast++;
        checks++; if (to || beat_last_q.size() != 6 || nlast != (ROW_TL ? 3 : 1)) begin
            errors++; $display("FAIL rowtl_count: got %0d beats %0d tlast, want 6/%0d", beat_last_q.size(), nlast, ROW_TL ? 3 : 1);
        end
        for (int i = 0; i < exp_last_q.size(); i++) begin
            checks++;
            if (i >= beat_last_q.size() || beat_last_q[i] !== exp_last_q[i] || beat_data_q[i] !== exp_data_q[i]) begin
                errors++; $display("FAIL rowtl_beat[%0d]: got last %b, want %b", i,
                    (i < beat_last_q.size()) ? beat_last_q[i] : 1'bx, exp_last_q[i]);
            end
        end
        checks++; if (done_q.size() != 1) begin
            errors++; $display("FAIL rowtl_done: got %0d done pulses, want 1", done_q.size());
        end
        $display("row_tlast: %0d tlast beats", nlast);
    endtask

    task automatic test_random();
        bit to;
        int rw, nr, bad;
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < MEMSZ; i++) mem[i] = $urandom;
            rw = $urandom_range(1, 9);
            nr = $urandom_range(1, 4);
            build_model(rw, nr);
            run_transfer(rw, nr, 2, to);
            bad = 0;
            if (beat_data_q.size() != exp_data_q.size() || addr_q.size() != exp_addr_q.size()) bad++;
            for (int i = 0; i < exp_data_q.size(); i++) begin
                if (i >= beat_data_q.size() || beat_data_q[i] !== exp_data_q[i] || beat_last_q[i] !== exp_last_q[i]) bad++;
                if (i >= addr_q.size() || addr_q[i] != exp_addr_q[i]) bad++;
            end
            checks++; if (to || bad != 0 || stall_viol != 0 || done_q.size() != 1) begin
                errors++; $display("FAIL random[%0d]: rw=%0d nr=%0d got beats=%0d bad=%0d stall=%0d done=%0d, want beats=%0d bad=0 stall=0 done=1",
                    it, rw, nr, beat_data_q.size(), bad, stall_viol, done_q.size(), exp_data_q.size());
            end
            $display("random[%0d]: rw=%0d nr=%0d beats=%0d", it, rw, nr, beat_data_q.size());
        end
    endtask

    initial begin
        for (int i = 0; i < MEMSZ; i++) mem[i] = 32'd0;
        test_reset();
        test_pad_skip();
        test_backpressure();
        test_zero_size();
        test_reset_mid();
        test_addr_wrap();
        test_row_tlast();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
